// File: rtl/arb_client_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter client.
package arb_client_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } arb_client_state_t;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_STARVE_MAX = 16;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_client_if.sv
// Producer, arbiter and bus signals of one arbiter client; master = client side.
interface arb_client_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_last;
    logic                    req;
    logic                    gnt;
    logic                    bus_valid;
    logic [DATA_W-1:0]       bus_data;
    logic                    bus_last;
    logic                    pkt_done;
    logic                    starve;
    logic [$clog2(DEPTH):0]  level;

    modport master (
        input  wr_valid, wr_data, wr_last, gnt,
        output wr_ready, req, bus_valid, bus_data, bus_last, pkt_done, starve, level
    );

    modport slave (
        output wr_valid, wr_data, wr_last, gnt,
        input  wr_ready, req, bus_valid, bus_data, bus_last, pkt_done, starve, level
    );
endinterface

// File: rtl/arb_client_fifo.sv
// Circular beat buffer of {last,data} with a count of queued packet-ending beats.
module arb_client_fifo
    import arb_client_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_last,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [$clog2(DEPTH):0] o_pkt_cnt,
    output logic [DATA_W-1:0]      o_head_data,
    output logic                   o_head_last
);
    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   r_pkt_cnt;
    logic               w_push;
    logic               w_pop;
    logic               w_last_in;
    logic               w_last_out;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_pkt_cnt = r_pkt_cnt;
    assign {o_head_last, o_head_data} = r_mem[r_rd_ptr];

    // Full blocks writes outright, even when a pop frees a slot this cycle.
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign w_last_in  = w_push && i_last;
    assign w_last_out = w_pop && o_head_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {i_last, i_data};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_last_in && !w_last_out) begin
                r_pkt_cnt <= r_pkt_cnt + LVL_W'(1);
            end else if (w_last_out && !w_last_in) begin
                r_pkt_cnt <= r_pkt_cnt - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/arb_client.sv
// Requester-side agent for the 4-way round-robin arbiter: buffers beats, requests, streams on grant.
// Optional starvation detector built when ARB_CLIENT_STARVE_EN is defined.
module arb_client
    import arb_client_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    arb_client_if.master  bus
);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    arb_client_state_t  r_state;
    logic               r_bus_valid;
    logic [DATA_W-1:0]  r_bus_data;
    logic               r_bus_last;
    logic               r_pkt_done;
    logic               w_full;
    logic               w_empty;
    logic [LVL_W-1:0]   w_level;
    logic [LVL_W-1:0]   w_pkt_cnt;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_head_last;
    logic               w_fire;

    arb_client_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus.wr_valid && bus.wr_ready),
        .i_data      (bus.wr_data),
        .i_last      (bus.wr_last),
        .i_pop       (w_fire),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level),
        .o_pkt_cnt   (w_pkt_cnt),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last)
    );

    // Grants outside REQ (stale or spurious) and grants on an empty buffer never pop.
    assign w_fire = (r_state == REQ) && bus.gnt && !w_empty;

    assign bus.wr_ready  = !rst && !w_full;
    assign bus.req       = (r_state == REQ);
    assign bus.level     = w_level;
    assign bus.bus_valid = r_bus_valid;
    assign bus.bus_data  = r_bus_data;
    assign bus.bus_last  = r_bus_last;
    assign bus.pkt_done  = r_pkt_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_bus_last  <= 1'b0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_bus_valid <= w_fire;
            r_bus_last  <= w_fire && w_head_last;
            r_pkt_done  <= w_fire && w_head_last;
            if (w_fire) begin
                r_bus_data <= w_head_data;
            end
            case (r_state)
                // Full without a last beat means a packet longer than the buffer.
                IDLE:    if ((w_pkt_cnt != '0) || w_full) r_state <= REQ;
                REQ:     if (w_fire && w_head_last) r_state <= HOLDOFF;
                HOLDOFF: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_CLIENT_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_nxt;
    logic             r_starve;

    // Saturating count of consecutive ungranted request cycles.
    always_comb begin
        w_starve_cnt_nxt = '0;
        if ((r_state == REQ) && !bus.gnt) begin
            if (r_starve_cnt == CNT_W'(STARVE_MAX)) begin
                w_starve_cnt_nxt = r_starve_cnt;
            end else begin
                w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_starve     <= (w_starve_cnt_nxt == CNT_W'(STARVE_MAX));
        end
    end

    assign bus.starve = r_starve;
`else
    logic w_unused_starve_max;

    assign w_unused_starve_max = |STARVE_MAX;
    assign bus.starve          = 1'b0;
`endif

endmodule

// File: tb/tb_arb_client.sv
// Randomized self-checking bench for arb_client against a queue-based packet model.
module tb_arb_client;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SMAX  = 16;
    localparam int          NPH   = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    arb_client_if #(.DATA_W(DW), .DEPTH(DEPTH)) u_if ();

    arb_client #(.DATA_W(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: beat queue, request flag, post-packet quiet cycles, starve count.
    logic [DW:0]   q [$];
    bit            req_m;
    int            gap;
    bit            exp_bv;
    bit            exp_bl;
    bit            exp_pd;
    logic [DW-1:0] exp_bd;
    int            scnt;

    int wr_pct   [NPH] = '{70, 90, 50, 100, 40, 80, 30};
    int last_pct [NPH] = '{30, 10, 50,   0, 25, 20, 40};
    int gnt_pct  [NPH] = '{50, 80, 20,  60,100,  0, 60};
    int ph_cyc   [NPH] = '{300,300,300, 60, 300, 40, 300};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_last();
        foreach (q[i]) if (q[i][DW]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        req_m  = 1'b0;
        gap    = 0;
        exp_bv = 1'b0;
        exp_bl = 1'b0;
        exp_pd = 1'b0;
        exp_bd = '0;
        scnt   = 0;
    endtask

    task automatic model_step();
        bit          fire;
        bit          push;
        bit          raise;
        logic [DW:0] head;
        head  = '0;
        fire  = req_m && u_if.gnt && (q.size() > 0);
        push  = u_if.wr_valid && (q.size() < DEPTH);
        raise = !req_m && (gap == 0) && (has_last() || (q.size() == DEPTH));
        if (req_m && !u_if.gnt) scnt = (scnt < SMAX) ? scnt + 1 : scnt;
        else                    scnt = 0;
        exp_bv = fire;
        exp_bl = 1'b0;
        exp_pd = 1'b0;
        if (fire) begin
            head   = q.pop_front();
            exp_bd = head[DW-1:0];
            exp_bl = head[DW];
            exp_pd = head[DW];
        end
        if (push) q.push_back({u_if.wr_last, u_if.wr_data});
        if (fire && head[DW]) begin
            req_m = 1'b0;
            gap   = 1;
        end else if (!req_m && gap > 0) begin
            gap--;
        end else if (raise) begin
            req_m = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit exp_st;
`ifdef ARB_CLIENT_STARVE_EN
        exp_st = (scnt == SMAX);
`else
        exp_st = 1'b0;
`endif
        chk("req",       u_if.req,       req_m);
        chk("wr_ready",  u_if.wr_ready,  q.size() < DEPTH);
        chk("level",     u_if.level,     q.size());
        chk("bus_valid", u_if.bus_valid, exp_bv);
        chk("bus_data",  u_if.bus_data,  exp_bd);
        chk("bus_last",  u_if.bus_last,  exp_bl);
        chk("pkt_done",  u_if.pkt_done,  exp_pd);
        chk("starve",    u_if.starve,    exp_st);
    endtask

    task automatic run_cycle(input bit wv, input logic [DW-1:0] wd, input bit wl, input bit g);
        @(negedge clk);
        check_outputs();
        u_if.wr_valid = wv;
        u_if.wr_data  = wd;
        u_if.wr_last  = wl;
        u_if.gnt      = g;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_inputs();
        u_if.wr_valid = 1'b0;
        u_if.wr_data  = '0;
        u_if.wr_last  = 1'b0;
        u_if.gnt      = 1'b0;
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear immediately.
    task automatic async_reset(input string tag);
        @(negedge clk);
        check_outputs();
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk({tag, "_req"},       u_if.req,       0);
        chk({tag, "_bus_valid"}, u_if.bus_valid, 0);
        chk({tag, "_level"},     u_if.level,     0);
        chk({tag, "_wr_ready"},  u_if.wr_ready,  0);
        chk({tag, "_pkt_done"},  u_if.pkt_done,  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #3;
        chk("rst_req",       u_if.req,       0);
        chk("rst_wr_ready",  u_if.wr_ready,  0);
        chk("rst_level",     u_if.level,     0);
        chk("rst_bus_valid", u_if.bus_valid, 0);
        chk("rst_bus_data",  u_if.bus_data,  0);
        chk("rst_starve",    u_if.starve,    0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step();

        // Three-beat packet, grant two cycles after req, held three cycles.
        run_cycle(1, 8'hA1, 0, 0);
        run_cycle(1, 8'hA2, 0, 0);
        run_cycle(1, 8'hA3, 1, 0);
        run_cycle(0, 8'h00, 0, 0);
        run_cycle(0, 8'h00, 0, 0);
        run_cycle(0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(0, 8'h00, 0, 1);
        // Stale grant after req drops.
        run_cycle(1, 8'hB1, 1, 1);
        for (int i = 0; i < 4; i++) run_cycle(0, 8'h00, 0, 0);
        // Alternating one-cycle grants.
        for (int i = 0; i < 6; i++) run_cycle(0, 8'h00, 0, (i % 2) == 0);

        // Reset while a two-beat packet is queued and requesting.
        run_cycle(1, 8'hC1, 0, 0);
        run_cycle(1, 8'hC2, 1, 0);
        run_cycle(0, 8'h00, 0, 0);
        run_cycle(0, 8'h00, 0, 0);
        chk("pre_rst_req", u_if.req, 1);
        async_reset("mid_rst");
        for (int i = 0; i < 6; i++) run_cycle(0, 8'h00, 0, 1);

        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++) begin
                run_cycle($urandom_range(99) < 32'(wr_pct[p]), DW'($urandom),
                          $urandom_range(99) < 32'(last_pct[p]),
                          $urandom_range(99) < 32'(gnt_pct[p]));
            end
        end

        async_reset("end_rst");
        for (int c = 0; c < 200; c++) begin
            run_cycle($urandom_range(99) < 60, DW'($urandom), $urandom_range(99) < 30,
                      $urandom_range(99) < 50);
        end
        @(negedge clk);
        check_outputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
